// File: rtl/score_tracker.sv
// Reaction-time score tracker: last/best/round count, new-best LED hold, 4-digit BCD view mux.
// Optional history register file enabled by defining SCORE_HISTORY_EN.
module score_tracker #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int HIST_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done,
  input  logic [3:0] score_a,
  input  logic [3:0] score_b,
  input  logic [3:0] score_c,
  input  logic [3:0] score_d,
  input  logic       clear,
  input  logic [2:0] view,
  output logic       busy,
  output logic       err,
  output logic       best_valid,
  output logic       new_best,
  output logic [7:0] rounds,
  output logic [3:0] disp_a,
  output logic [3:0] disp_b,
  output logic [3:0] disp_c,
  output logic [3:0] disp_d
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic          r_busy;
  logic          r_err;
  logic [15:0]   r_cap;
  logic [15:0]   r_last;
  logic [15:0]   r_best;
  logic          r_best_valid;
  logic [CW-1:0] r_nb_cnt;
  logic [7:0]    r_rounds;
  logic [15:0]   r_disp;

  logic [15:0]   w_score;
  logic          w_bad;
  logic          w_accept;
  logic          w_commit;
  logic          w_better;
  logic [7:0]    w_rounds_inc;
  logic [15:0]   w_hist_data;
  logic [15:0]   w_view_data;
  logic [$clog2(HIST_DEPTH)-1:0] w_hidx;

  assign w_score  = {score_d, score_c, score_b, score_a};
  assign w_bad    = (score_a > 4'd9) | (score_b > 4'd9) | (score_c > 4'd9) | (score_d > 4'd9);
  assign w_accept = done & ~r_busy & ~clear;
  // A rejected capture still occupies the busy cycle but never commits.
  assign w_commit = r_busy & ~r_err & ~clear;
  // Packed BCD with thousands on top orders the same as the binary value.
  assign w_better = ~r_best_valid | (r_cap < r_best);
  assign w_hidx   = view[1:0];

  always_comb begin
    w_rounds_inc = r_rounds;
    if (r_rounds == 8'h99)
      w_rounds_inc = 8'h99;
    else if (r_rounds[3:0] == 4'd9)
      w_rounds_inc = {r_rounds[7:4] + 4'd1, 4'd0};
    else
      w_rounds_inc = {r_rounds[7:4], r_rounds[3:0] + 4'd1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cap        <= '0;
      r_last       <= '0;
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_nb_cnt     <= '0;
      r_rounds     <= '0;
      r_disp       <= '0;
    end else if (clear) begin
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cap        <= '0;
      r_last       <= '0;
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_nb_cnt     <= '0;
      r_rounds     <= '0;
      r_disp       <= '0;
    end else begin
      r_busy <= w_accept;
      r_err  <= w_accept & w_bad;
      if (w_accept)
        r_cap <= w_score;
      if (w_commit) begin
        r_last   <= r_cap;
        r_rounds <= w_rounds_inc;
      end
      if (w_commit && w_better) begin
        r_best       <= r_cap;
        r_best_valid <= 1'b1;
        r_nb_cnt     <= CW'(HOLD_CYCLES);
      end else if (r_nb_cnt != '0) begin
        r_nb_cnt <= r_nb_cnt - 1'b1;
      end
      r_disp <= w_view_data;
    end
  end

`ifdef SCORE_HISTORY_EN
  logic [15:0] r_hist [HIST_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (w_commit) begin
      r_hist[0] <= r_cap;
      for (int i = 1; i < HIST_DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  assign w_hist_data = r_hist[w_hidx];
`else
  // Without storage only the newest entry exists, and it is the last score.
  assign w_hist_data = (w_hidx == '0) ? r_last : 16'h0000;
`endif

  always_comb begin
    w_view_data = 16'h0000;
    case (view)
      3'd0:    w_view_data = r_last;
      3'd1:    w_view_data = r_best_valid ? r_best : 16'h0000;
      3'd2:    w_view_data = {8'h00, r_rounds};
      3'd3:    w_view_data = 16'h0000;
      default: w_view_data = w_hist_data;
    endcase
  end

  assign busy       = r_busy;
  assign err        = r_err;
  assign best_valid = r_best_valid;
  assign new_best   = (r_nb_cnt != '0);
  assign rounds     = r_rounds;
  assign disp_a     = r_disp[3:0];
  assign disp_b     = r_disp[7:4];
  assign disp_c     = r_disp[11:8];
  assign disp_d     = r_disp[15:12];

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with a short new_best hold; expectations hand-computed.
module tb_score_tracker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done = 1'b0;
  logic [3:0] score_a = '0, score_b = '0, score_c = '0, score_d = '0;
  logic       clear = 1'b0;
  logic [2:0] view = '0;
  logic       busy, err, best_valid, new_best;
  logic [7:0] rounds;
  logic [3:0] disp_a, disp_b, disp_c, disp_d;

  int vectors = 0;
  int miscompares = 0;
  int cnt;
  int exp_r;

  score_tracker #(.HOLD_CYCLES(8), .HIST_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .done(done),
    .score_a(score_a), .score_b(score_b), .score_c(score_c), .score_d(score_d),
    .clear(clear), .view(view), .busy(busy), .err(err), .best_valid(best_valid),
    .new_best(new_best), .rounds(rounds),
    .disp_a(disp_a), .disp_b(disp_b), .disp_c(disp_c), .disp_d(disp_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses done for one cycle; returns at the negedge of T+1.
  task automatic send(input logic [3:0] d, input logic [3:0] c, input logic [3:0] b, input logic [3:0] a);
    @(negedge clk);
    done = 1'b1; score_d = d; score_c = c; score_b = b; score_a = a;
    @(negedge clk);
    done = 1'b0;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {disp_d, disp_c, disp_b, disp_a};
  endfunction

  initial begin
    tick(1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_best_valid", {15'd0, best_valid}, 16'd0);
    chk("rst_new_best", {15'd0, new_best}, 16'd0);
    chk("rst_rounds", {8'd0, rounds}, 16'd0);
    chk("rst_disp", disp(), 16'h0000);
    rst_n = 1'b1;
    view = 3'd1;

    send(4'd0, 4'd2, 4'd4, 4'd5);
    chk("first_busy", {15'd0, busy}, 16'd1);
    chk("first_err", {15'd0, err}, 16'd0);
    tick(1);
    chk("first_best_valid", {15'd0, best_valid}, 16'd1);
    chk("first_rounds", {8'd0, rounds}, 16'h0001);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (new_best) cnt++;
      tick(1);
    end
    chk("hold_cycles", 16'(cnt), 16'd8);
    chk("first_best_disp", disp(), 16'h0245);

    send(4'd0, 4'd3, 4'd1, 4'd0);
    tick(1);
    chk("worse_new_best", {15'd0, new_best}, 16'd0);
    chk("worse_rounds", {8'd0, rounds}, 16'h0002);
    tick(1);
    chk("worse_best_disp", disp(), 16'h0245);

    send(4'd0, 4'd1, 4'd9, 4'd8);
    tick(1);
    chk("better_new_best", {15'd0, new_best}, 16'd1);
    chk("better_rounds", {8'd0, rounds}, 16'h0003);
    tick(1);
    chk("better_best_disp", disp(), 16'h0198);
    view = 3'd4;
    tick(1);
    chk("view4", disp(), 16'h0198);
    view = 3'd5;
    tick(1);
`ifdef SCORE_HISTORY_EN
    chk("view5", disp(), 16'h0310);
`else
    chk("view5", disp(), 16'h0000);
`endif
    view = 3'd7;
    tick(1);
    chk("view7", disp(), 16'h0000);
    tick(10);
    view = 3'd1;

    send(4'd0, 4'd1, 4'd9, 4'd8);
    tick(1);
    chk("equal_new_best", {15'd0, new_best}, 16'd0);
    chk("equal_rounds", {8'd0, rounds}, 16'h0004);
    tick(1);
    chk("equal_best_disp", disp(), 16'h0198);
    view = 3'd2;
    tick(1);
    chk("view2_rounds", disp(), 16'h0004);
    view = 3'd3;
    tick(1);
    chk("view3_blank", disp(), 16'h0000);

    send(4'd0, 4'd1, 4'hA, 4'd3);
    chk("bad_err_t1", {15'd0, err}, 16'd1);
    chk("bad_busy_t1", {15'd0, busy}, 16'd1);
    tick(1);
    chk("bad_err_t2", {15'd0, err}, 16'd0);
    chk("bad_rounds", {8'd0, rounds}, 16'h0004);
    view = 3'd0;
    tick(1);
    chk("bad_last", disp(), 16'h0198);
    view = 3'd1;
    tick(1);
    chk("bad_best", disp(), 16'h0198);

    @(negedge clk);
    done = 1'b1; score_d = 4'd0; score_c = 4'd5; score_b = 4'd0; score_a = 4'd0;
    @(negedge clk);
    chk("dbl_busy", {15'd0, busy}, 16'd1);
    score_c = 4'd4;
    @(negedge clk);
    done = 1'b0;
    chk("dbl_err", {15'd0, err}, 16'd0);
    chk("dbl_busy_after", {15'd0, busy}, 16'd0);
    chk("dbl_rounds", {8'd0, rounds}, 16'h0005);
    view = 3'd0;
    tick(1);
    chk("dbl_last", disp(), 16'h0500);
    chk("dbl_rounds_hold", {8'd0, rounds}, 16'h0005);

    for (int i = 1; i <= 100; i++) begin
      send(4'd9, 4'd9, 4'd9, 4'd9);
      tick(1);
      exp_r = (5 + i > 99) ? 99 : 5 + i;
      chk($sformatf("rounds_%0d", i), {8'd0, rounds}, {8'd0, bcd(exp_r)});
    end
    tick(1);
    chk("last_9999", disp(), 16'h9999);
    view = 3'd1;
    tick(1);
    chk("best_after_9999", disp(), 16'h0198);

    @(negedge clk);
    clear = 1'b1; done = 1'b1;
    score_d = 4'd0; score_c = 4'd1; score_b = 4'd0; score_a = 4'd0;
    @(negedge clk);
    clear = 1'b0; done = 1'b0;
    chk("clr_busy", {15'd0, busy}, 16'd0);
    chk("clr_rounds", {8'd0, rounds}, 16'h0000);
    chk("clr_best_valid", {15'd0, best_valid}, 16'd0);
    chk("clr_new_best", {15'd0, new_best}, 16'd0);
    chk("clr_disp_now", disp(), 16'h0000);
    tick(1);
    chk("clr_best_disp", disp(), 16'h0000);
    chk("clr_rounds_hold", {8'd0, rounds}, 16'h0000);
    view = 3'd0;
    tick(1);
    chk("clr_last_disp", disp(), 16'h0000);
    view = 3'd4;
    tick(1);
    chk("clr_hist_disp", disp(), 16'h0000);

    send(4'd0, 4'd7, 4'd7, 4'd7);
    tick(1);
    chk("post_best_valid", {15'd0, best_valid}, 16'd1);
    chk("post_rounds", {8'd0, rounds}, 16'h0001);
    chk("post_new_best", {15'd0, new_best}, 16'd1);
    view = 3'd1;
    tick(1);
    chk("post_best_disp", disp(), 16'h0777);
    view = 3'd2;
    tick(1);
    chk("post_view2", disp(), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
